ag32gbd_frame_scanner: RTL and testbench

Frame-level controller that drives the single-pixel sampler across a full image. It walks PixelX/PixelY in raster order and issues one SampleStart per pixel. It collects each 2-bit SampledValue, packs four pixels per byte and writes the bytes into the frame buffer. It sits between the capture control logic (frame start/abort) and the sampler/frame-buffer pair.

---
 rtl/ag32gbd_frame_scanner.sv | 197 +++++++++++++++++++
 tb/tb_ag32gbd_frame_scanner.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag32gbd_frame_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ag32gbd_frame_scanner                                                    |
// | Raster-scans the pixel sampler, packs 2-bit samples four to a byte and   |
// | writes them to the frame buffer.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ag32gbd_frame_scanner #(
    parameter int WIDTH        = 128,
    parameter int HEIGHT       = 112,
    parameter int DONE_TIMEOUT = 255,
    parameter int ADDR_W       = 12
) (
    input  logic              sys_clock,
    input  logic              sys_reset,
    input  logic              FrameStart,
    input  logic              FrameAbort,
    output logic              Busy,
    output logic              FrameDone,
    output logic              FrameError,
    output logic              SampleStart,
    output logic [6:0]        PixelX,
    output logic [6:0]        PixelY,
    input  logic              SampleDone,
    input  logic [1:0]        SampledValue,
    output logic              PixWrEn,
    output logic [ADDR_W-1:0] PixWrAddr,
    output logic [7:0]        PixWrData
);

    localparam int C_BPL   = WIDTH / 4;
    localparam int C_TMO_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_WAIT_DONE  = 3'd2,
        S_WAIT_CLEAR = 3'd3,
        S_WRITE      = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                ss_q;
    logic                ss_cnt_q;
    logic [6:0]          x_q;
    logic [6:0]          y_q;
    logic [7:0]          pack_q;
    logic [C_TMO_W-1:0]  tmo_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [7:0]          wr_data_q;

    logic [ADDR_W-1:0]   wr_addr_d;
    logic [7:0]          pack_d;
    logic                x_wrap_d;
    logic                last_pix_d;
    logic                tmo_exp_d;

    assign wr_addr_d  = ADDR_W'(32'(y_q) * C_BPL + 32'(x_q[6:2]));
    assign x_wrap_d   = (x_q == 7'(WIDTH - 1));
    assign last_pix_d = x_wrap_d && (y_q == 7'(HEIGHT - 1));
    // Compared one short so the error pulse lands exactly DONE_TIMEOUT cycles after entry.
    assign tmo_exp_d  = (tmo_q == C_TMO_W'(DONE_TIMEOUT - 1));

    always_comb begin
        pack_d                      = pack_q;
        pack_d[{x_q[1:0], 1'b0} +: 2] = SampledValue;
    end

    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ss_q      <= 1'b0;
            ss_cnt_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            pack_q    <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (state_q != S_IDLE && FrameAbort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                ss_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (FrameStart && !FrameAbort) begin
                            x_q      <= '0;
                            y_q      <= '0;
                            pack_q   <= '0;
                            tmo_q    <= '0;
                            ss_cnt_q <= 1'b0;
                            busy_q   <= 1'b1;
                            ss_q     <= 1'b1;
                            state_q  <= S_START;
                        end
                    end
                    S_START: begin
                        if (ss_cnt_q) begin
                            ss_cnt_q <= 1'b0;
                            ss_q     <= 1'b0;
                            tmo_q    <= '0;
                            state_q  <= S_WAIT_DONE;
                        end else begin
                            ss_cnt_q <= 1'b1;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (SampleDone) begin
                            pack_q  <= pack_d;
                            tmo_q   <= '0;
                            state_q <= S_WAIT_CLEAR;
                        end else if (tmo_exp_d) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_q + C_TMO_W'(1);
                        end
                    end
                    S_WAIT_CLEAR: begin
                        if (!SampleDone) begin
                            if (x_q[1:0] == 2'd3) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= wr_addr_d;
                                wr_data_q <= pack_q;
                                state_q   <= S_WRITE;
                            end else begin
                                // Byte not complete, so X cannot be at the line end here.
                                x_q      <= x_q + 7'd1;
                                ss_q     <= 1'b1;
                                ss_cnt_q <= 1'b0;
                                state_q  <= S_START;
                            end
                        end else if (tmo_exp_d) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_q + C_TMO_W'(1);
                        end
                    end
                    S_WRITE: begin
                        if (last_pix_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            if (x_wrap_d) begin
                                x_q <= '0;
                                y_q <= y_q + 7'd1;
                            end else begin
                                x_q <= x_q + 7'd1;
                            end
                            ss_q     <= 1'b1;
                            ss_cnt_q <= 1'b0;
                            state_q  <= S_START;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ss_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Busy        = busy_q;
    assign FrameDone   = done_q;
    assign FrameError  = err_q;
    assign SampleStart = ss_q;
    assign PixelX      = x_q;
    assign PixelY      = y_q;
    assign PixWrEn     = wr_en_q;
    assign PixWrAddr   = wr_addr_q;
    assign PixWrData   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ag32gbd_frame_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ag32gbd_frame_scanner                                                 |
// | Scoreboard bench with a randomized sampler model and frame reference.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ag32gbd_frame_scanner;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int TO = 255;
    localparam int AW = 12;
    localparam int NB = W * H / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          FrameStart = 1'b0;
    logic          FrameAbort = 1'b0;
    logic          Busy, FrameDone, FrameError, SampleStart;
    logic [6:0]    PixelX, PixelY;
    logic          SampleDone;
    logic [1:0]    SampledValue;
    logic          PixWrEn;
    logic [AW-1:0] PixWrAddr;
    logic [7:0]    PixWrData;

    ag32gbd_frame_scanner #(
        .WIDTH(W), .HEIGHT(H), .DONE_TIMEOUT(TO), .ADDR_W(AW)
    ) dut (
        .sys_clock   (clk),
        .sys_reset   (rst),
        .FrameStart  (FrameStart),
        .FrameAbort  (FrameAbort),
        .Busy        (Busy),
        .FrameDone   (FrameDone),
        .FrameError  (FrameError),
        .SampleStart (SampleStart),
        .PixelX      (PixelX),
        .PixelY      (PixelY),
        .SampleDone  (SampleDone),
        .SampledValue(SampledValue),
        .PixWrEn     (PixWrEn),
        .PixWrAddr   (PixWrAddr),
        .PixWrData   (PixWrData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t        exp_q[$];
    logic [1:0] pixval [H][W];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, last_wr_cyc = -100;
    int pix_idx = 0;
    bit sampler_on = 1'b1, abort_flag = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Random image; expected bytes derived directly from pixel values.
    function automatic void prep_frame(int nbytes);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pixval[y][x] = 2'($urandom_range(0, 3));
        for (int a = 0; a < nbytes; a++) begin
            int y  = a / (W / 4);
            int xb = (a % (W / 4)) * 4;
            int d  = 0;
            for (int n = 0; n < 4; n++) d += int'(pixval[y][xb + n]) << (2 * n);
            exp_q.push_back('{addr: AW'(a), data: 8'(d)});
        end
    endfunction

    // Sampler model: random latency and done stretch, checks raster order and pin stability.
    initial begin : sampler
        int sx, sy, lat, st, ss_len;
        bit stable;
        SampleDone   = 1'b0;
        SampledValue = 2'd0;
        forever begin
            @(negedge clk);
            if (sampler_on && SampleStart && !rst) begin
                sx = int'(PixelX);
                sy = int'(PixelY);
                chk("raster_x", 32'(sx), 32'(pix_idx % W));
                chk("raster_y", 32'(sy), 32'(pix_idx / W));
                pix_idx++;
                ss_len = 1;
                stable = 1'b1;
                lat = int'($urandom_range(3, 10));
                st  = int'($urandom_range(1, 7));
                for (int i = 1; i < lat; i++) begin
                    @(negedge clk);
                    if (SampleStart) ss_len++;
                    if (int'(PixelX) != sx || int'(PixelY) != sy) stable = 1'b0;
                end
                SampleDone   = 1'b1;
                SampledValue = pixval[sy % H][sx % W];
                for (int i = 0; i < st; i++) begin
                    @(negedge clk);
                    if (SampleStart) ss_len++;
                    if (int'(PixelX) != sx || int'(PixelY) != sy) stable = 1'b0;
                end
                SampleDone   = 1'b0;
                SampledValue = 2'($urandom_range(0, 3));
                if (!abort_flag) begin
                    chk("samplestart_len", 32'(ss_len), 32'd2);
                    chk("pixel_stable", 32'(stable), 32'd1);
                end
            end
        end
    end

    // Write / done / error monitor against the scoreboard queue.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (PixWrEn) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(PixWrAddr), 32'(e.addr));
                chk("wr_data", 32'(PixWrData), 32'(e.data));
            end
            last_wr_cyc = cyc;
            wr_cnt++;
        end
        if (FrameDone) begin
            done_cnt++;
            chk("done_after_last_write", 32'(cyc - last_wr_cyc), 32'd1);
        end
        if (FrameError) err_cnt++;
    end

    task automatic start_frame();
        @(negedge clk);
        FrameStart = 1'b1;
        @(negedge clk);
        FrameStart = 1'b0;
        chk("start_busy", 32'(Busy), 32'd1);
        chk("start_samplestart", 32'(SampleStart), 32'd1);
        chk("start_x", 32'(PixelX), 32'd0);
        chk("start_y", 32'(PixelY), 32'd0);
    endtask

    task automatic wait_done(bit poke);
        int n = 0;
        while (!FrameDone && n < 6000) begin
            @(negedge clk);
            FrameStart = poke && ($urandom_range(0, 15) == 0);
            n++;
        end
        FrameStart = 1'b0;
        chk("frame_done_seen", 32'(FrameDone), 32'd1);
    endtask

    task automatic full_frame(bit poke);
        int wr0 = wr_cnt, d0 = done_cnt, e0 = err_cnt;
        pix_idx = 0;
        prep_frame(NB);
        start_frame();
        wait_done(poke);
        @(negedge clk);
        chk("frame_writes", 32'(wr_cnt - wr0), 32'(NB));
        chk("frame_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("frame_err_cnt", 32'(err_cnt - e0), 32'd0);
        chk("frame_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("frame_busy_low", 32'(Busy), 32'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, hits, wr0, d0, e0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(FrameDone), 32'd0);
        chk("rst_err", 32'(FrameError), 32'd0);
        chk("rst_ss", 32'(SampleStart), 32'd0);
        chk("rst_x", 32'(PixelX), 32'd0);
        chk("rst_y", 32'(PixelY), 32'd0);
        chk("rst_wren", 32'(PixWrEn), 32'd0);
        chk("rst_addr", 32'(PixWrAddr), 32'd0);
        chk("rst_data", 32'(PixWrData), 32'd0);
        rst = 1'b0;

        full_frame(1'b0);
        full_frame(1'b1);

        // Start together with abort in IDLE is ignored.
        @(negedge clk);
        FrameStart = 1'b1;
        FrameAbort = 1'b1;
        @(negedge clk);
        FrameStart = 1'b0;
        FrameAbort = 1'b0;
        chk("start_abort_busy", 32'(Busy), 32'd0);
        chk("start_abort_ss", 32'(SampleStart), 32'd0);
        @(negedge clk);
        chk("start_abort_busy2", 32'(Busy), 32'd0);

        // Sampler silent: timeout.
        sampler_on = 1'b0;
        e0 = err_cnt;
        wr0 = wr_cnt;
        start_frame();
        n = 0;
        while (SampleStart && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (!FrameError && n < 400) begin @(negedge clk); n++; end
        chk("timeout_cycles", 32'(n), 32'(TO));
        chk("timeout_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        chk("timeout_pulse_len", 32'(FrameError), 32'd0);
        chk("timeout_err_cnt", 32'(err_cnt - e0), 32'd1);
        chk("timeout_no_write", 32'(wr_cnt - wr0), 32'd0);
        sampler_on = 1'b1;

        // Abort at pixel (5,3).
        pix_idx = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        prep_frame(3 * (W / 4) + 1);
        start_frame();
        n = 0;
        while (!(SampleStart && PixelX == 7'd5 && PixelY == 7'd3) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_pixel_reached", 32'(n < 3000), 32'd1);
        FrameAbort = 1'b1;
        abort_flag = 1'b1;
        @(negedge clk);
        FrameAbort = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_ss", 32'(SampleStart), 32'd0);
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (SampleStart || PixWrEn || FrameDone || Busy) hits++;
        end
        chk("abort_quiet", 32'(hits), 32'd0);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_no_err", 32'(err_cnt - e0), 32'd0);
        abort_flag = 1'b0;
        full_frame(1'b0);

        // Reset asserted during WRITE.
        pix_idx = 0;
        prep_frame(NB);
        start_frame();
        n = 0;
        while (!PixWrEn && n < 3000) begin @(negedge clk); n++; end
        chk("write_reached", 32'(PixWrEn), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_wren", 32'(PixWrEn), 32'd0);
        chk("arst_ss", 32'(SampleStart), 32'd0);
        chk("arst_addr", 32'(PixWrAddr), 32'd0);
        chk("arst_data", 32'(PixWrData), 32'd0);
        chk("arst_x", 32'(PixelX), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (60) begin
            @(negedge clk);
            if (PixWrEn || SampleStart || Busy) hits++;
        end
        chk("post_reset_quiet", 32'(hits), 32'd0);

        full_frame(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
